// File: rtl/dmfb_pkg.sv
// dmfb_pkg
// Definitions shared by the DMFB move sequencer and the period timer.
//   state_t     : sequencer FSM states
//   PHASES_DEF  : default number of electrode phases
//   CNT_W_DEF   : default width of the step-count field
//   CC_FAST/SLOW: clockControl encodings understood by the period timer
package dmfb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    STEP = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int PHASES_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  // Timer period select: FAST = 60 ms (stepping), SLOW = 2 s (holding)
  localparam logic CC_FAST = 1'b0;
  localparam logic CC_SLOW = 1'b1;

endpackage

// File: rtl/dmfb_move_sequencer_if.sv
// dmfb_move_sequencer_if
// Move-command bus between the host/command logic and the sequencer.
//   cmd_valid : command present (master)
//   cmd_ready : sequencer can accept (slave)
//   cmd_dir   : 0 = forward, 1 = reverse
//   cmd_steps : number of phase steps
//   cmd_hold  : hold for one slow period after the last step
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high; the master keeps the payload stable while
// cmd_valid is high, and the slave never queues a command.
interface dmfb_move_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_hold;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/dmfb_tick_edge.sv
// dmfb_tick_edge
// Rising-edge detector for the period timer's clockOut level.
//   i_clk       : system clock
//   i_rst       : synchronous active-high reset
//   i_tick      : timer clockOut level
//   o_tick_rise : high for the one cycle where i_tick is high and was low
//                 at the previous edge
module dmfb_tick_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  output logic o_tick_rise
);
  logic r_tick_q;

  // Updates every cycle regardless of sequencer state, so a level that
  // stays high yields a single rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_tick_q <= 1'b0;
    else       r_tick_q <= i_tick;
  end

  assign o_tick_rise = i_tick & ~r_tick_q;
endmodule

// File: rtl/dmfb_move_sequencer.sv
// dmfb_move_sequencer
// Steps a one-hot electrode phase pattern forward/backward, one phase per
// timer tick, and drives the timer's period select and restart lines.
//   clockIn      : system clock (rising edge)
//   reset_t      : synchronous active-high reset
//   tickIn       : timer clockOut level
//   cmd_if       : move-command bus (slave side)
//   abort        : cancel the current move, phase kept, no done
//   clockControl : CC_FAST while idle/arming/stepping, CC_SLOW while holding
//   timer_reset  : one full-cycle timer restart on entry to ARM or HOLD
//   phase_out    : one-hot electrode enable
//   busy         : state is not IDLE
//   done         : one-cycle pulse after a normal completion
//   dbg_state    : current FSM state
module dmfb_move_sequencer
  import dmfb_pkg::*;
#(
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clockIn,
  input  logic                 reset_t,
  input  logic                 tickIn,
  dmfb_move_sequencer_if.slave cmd_if,
  input  logic                 abort,
  output logic                 clockControl,
  output logic                 timer_reset,
  output logic [PHASES-1:0]    phase_out,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);
  localparam int PIDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(PHASES - 1);

  state_t            r_state, w_state_nxt;
  logic [PIDX_W-1:0] r_phase, w_phase_nxt;
  logic [CNT_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_timer_reset, w_timer_reset_nxt;
  logic              w_tick_rise;

  dmfb_tick_edge u_tick_edge (
    .i_clk       (clockIn),
    .i_rst       (reset_t),
    .i_tick      (tickIn),
    .o_tick_rise (w_tick_rise)
  );

  always_ff @(posedge clockIn) begin
    if (reset_t) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_remaining   <= '0;
      r_dir         <= 1'b0;
      r_hold        <= 1'b0;
      r_done        <= 1'b0;
      r_timer_reset <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_remaining   <= w_remaining_nxt;
      r_dir         <= w_dir_nxt;
      r_hold        <= w_hold_nxt;
      r_done        <= w_done_nxt;
      r_timer_reset <= w_timer_reset_nxt;
    end
  end

  // done and timer_reset are registered: each is raised by the transition
  // that needs it and therefore lasts exactly one full clock cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_remaining_nxt   = r_remaining;
    w_dir_nxt         = r_dir;
    w_hold_nxt        = r_hold;
    w_done_nxt        = 1'b0;
    w_timer_reset_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          w_dir_nxt       = cmd_if.cmd_dir;
          w_hold_nxt      = cmd_if.cmd_hold;
          w_remaining_nxt = cmd_if.cmd_steps;
          if (cmd_if.cmd_steps != '0) begin
            w_state_nxt       = ARM;
            w_timer_reset_nxt = 1'b1;
          end else if (cmd_if.cmd_hold) begin
            w_state_nxt       = HOLD;
            w_timer_reset_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end

      // Timer is being restarted this cycle; any tick now is stale.
      ARM: begin
        w_state_nxt = abort ? IDLE : STEP;
      end

      STEP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_tick_rise) begin
          if (r_dir) w_phase_nxt = (r_phase == '0) ? LAST_IDX : r_phase - 1'b1;
          else       w_phase_nxt = (r_phase == LAST_IDX) ? '0 : r_phase + 1'b1;
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == CNT_W'(1)) begin
            if (r_hold) begin
              w_state_nxt       = HOLD;
              w_timer_reset_nxt = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_tick_rise) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd_if.cmd_ready = (r_state == IDLE);
  assign busy             = (r_state != IDLE);
  assign clockControl     = (r_state == HOLD) ? CC_SLOW : CC_FAST;
  assign timer_reset      = r_timer_reset;
  assign done             = r_done;
  assign dbg_state        = r_state;
  assign phase_out        = {{(PHASES-1){1'b0}}, 1'b1} << r_phase;
endmodule

// File: tb/tb_dmfb_move_sequencer.sv
module tb_dmfb_move_sequencer;
  import dmfb_pkg::*;

  localparam int W = 10;

  logic       clk;
  logic       reset_t;
  logic       tickIn;
  logic       abort;
  logic       clockControl;
  logic       timer_reset;
  logic [3:0] phase_out;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  dmfb_move_sequencer_if #(.CNT_W(8)) bus ();

  dmfb_move_sequencer #(.PHASES(4), .CNT_W(8)) dut (
    .clockIn      (clk),
    .reset_t      (reset_t),
    .tickIn       (tickIn),
    .cmd_if       (bus),
    .abort        (abort),
    .clockControl (clockControl),
    .timer_reset  (timer_reset),
    .phase_out    (phase_out),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Word layout: {phase_changed, done, timer_reset, clockControl, busy,
  //               cmd_ready, phase_out[3:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prb_q[$];
  int           errors = 0;
  int           checks = 0;
  int           n_probe = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           end_req = 1'b0;
  logic [3:0]   last_ph = 4'b0001;
  logic         chg;
  logic [W-1:0] got_w;
  logic [W-1:0] exp_w;

  function automatic logic [W-1:0] mk(bit c, bit d, bit tr, bit cc, bit bsy,
                                      bit rdy, logic [3:0] ph);
    return {c, d, tr, cc, bsy, rdy, ph};
  endfunction

  task automatic push_ev(bit c, bit d, bit tr, bit cc, bit bsy, bit rdy,
                         logic [3:0] ph);
    exp_q.push_back(mk(c, d, tr, cc, bsy, rdy, ph));
  endtask

  task automatic probe(bit d, bit tr, bit cc, bit bsy, bit rdy, logic [3:0] ph);
    prb_q.push_back(mk(1'b0, d, tr, cc, bsy, rdy, ph));
  endtask

  // Monitor: sole owner of the counters.
  always @(negedge clk) begin
    cyc++;
    while (prb_q.size() > 0) begin
      exp_w = prb_q.pop_front();
      got_w = mk(1'b0, done, timer_reset, clockControl, busy, bus.cmd_ready, phase_out);
      checks++;
      n_probe++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL probe%0d at %0t: got=%b want=%b state=%s", n_probe, $time,
                 got_w, exp_w, dbg_state.name());
      end
    end
    if (mon_en) begin
      chg = (phase_out !== last_ph);
      if (chg || done || timer_reset) begin
        got_w = mk(chg, done, timer_reset, clockControl, busy, bus.cmd_ready, phase_out);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event at %0t: got=%b want=none state=%s",
                   $time, got_w, dbg_state.name());
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            errors++;
            $display("FAIL event at %0t: got=%b want=%b state=%s", $time,
                     got_w, exp_w, dbg_state.name());
          end
        end
      end
    end
    last_ph = phase_out;
    if (end_req || cyc > 20000) begin
      checks++;
      if (exp_q.size() != 0 || cyc > 20000) begin
        errors++;
        $display("FAIL drain: got pending=%0d want=0 cycles=%0d", exp_q.size(), cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(bit dir, logic [7:0] steps, bit hold);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_steps = steps;
    bus.cmd_hold  = hold;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_tick(int gap, int high);
    repeat (gap) @(posedge clk);
    #1 tickIn = 1'b1;
    repeat (high) @(posedge clk);
    #1 tickIn = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_t = 1'b1;
    @(posedge clk); #1 reset_t = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_t       = 1'b1;
    tickIn        = 1'b0;
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_hold  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 probe(0, 0, 0, 0, 1, 4'b0001);
    @(posedge clk); #1 reset_t = 1'b0;
    mon_en = 1'b1;

    // Forward 5 steps, no hold
    push_ev(0, 0, 1, 0, 1, 0, 4'b0001);
    send_cmd(1'b0, 8'd5, 1'b0);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0010); do_tick(19, 1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0100); do_tick(19, 1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b1000); do_tick(19, 1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0001); do_tick(19, 1);
    push_ev(1, 1, 0, 0, 0, 1, 4'b0010); do_tick(19, 1);
    repeat (5) @(posedge clk);

    // Reverse 2 steps from phase 0 (wrap-around)
    push_ev(1, 0, 0, 0, 0, 1, 4'b0001); do_reset();
    push_ev(0, 0, 1, 0, 1, 0, 4'b0001);
    send_cmd(1'b1, 8'd2, 1'b0);
    push_ev(1, 0, 0, 0, 1, 0, 4'b1000); do_tick(19, 1);
    push_ev(1, 1, 0, 0, 0, 1, 4'b0100); do_tick(19, 1);
    repeat (5) @(posedge clk);

    // Forward 3 steps then hold
    push_ev(0, 0, 1, 0, 1, 0, 4'b0100);
    send_cmd(1'b0, 8'd3, 1'b1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b1000); do_tick(19, 1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0001); do_tick(19, 1);
    push_ev(1, 0, 1, 1, 1, 0, 4'b0010); do_tick(19, 1);
    push_ev(0, 1, 0, 0, 0, 1, 4'b0010); do_tick(19, 1);
    repeat (5) @(posedge clk);

    // Abort after 2 of 6 steps; abort coincides with a tick rise
    push_ev(1, 0, 0, 0, 0, 1, 4'b0001); do_reset();
    push_ev(0, 0, 1, 0, 1, 0, 4'b0001);
    send_cmd(1'b0, 8'd6, 1'b0);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0010); do_tick(19, 1);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0100); do_tick(19, 1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1; tickIn = 1'b1;
    @(posedge clk); #1 abort = 1'b0; tickIn = 1'b0;
    probe(0, 0, 0, 0, 1, 4'b0100);
    do_tick(5, 1);
    @(posedge clk); #1 probe(0, 0, 0, 0, 1, 4'b0100);
    repeat (5) @(posedge clk);

    // Reverse 2 steps with a tick held high 50 cycles; command during STEP
    push_ev(0, 0, 1, 0, 1, 0, 4'b0100);
    send_cmd(1'b1, 8'd2, 1'b0);
    push_ev(1, 0, 0, 0, 1, 0, 4'b0010);
    repeat (19) @(posedge clk);
    #1 tickIn = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_steps = 8'd7; bus.cmd_hold = 1'b1;
    probe(0, 0, 0, 1, 0, 4'b0010);
    repeat (3) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (37) @(posedge clk);
    #1 tickIn = 1'b0;
    push_ev(1, 1, 0, 0, 0, 1, 4'b0001); do_tick(19, 1);
    repeat (5) @(posedge clk);

    // Reset while holding
    push_ev(0, 0, 1, 0, 1, 0, 4'b0001);
    send_cmd(1'b0, 8'd1, 1'b1);
    push_ev(1, 0, 1, 1, 1, 0, 4'b0010); do_tick(19, 1);
    repeat (5) @(posedge clk);
    push_ev(1, 0, 0, 0, 0, 1, 4'b0001); do_reset();
    repeat (3) @(posedge clk);

    // Zero steps with hold: straight to HOLD, done after next tick
    push_ev(0, 0, 1, 1, 1, 0, 4'b0001);
    send_cmd(1'b0, 8'd0, 1'b1);
    push_ev(0, 1, 0, 0, 0, 1, 4'b0001); do_tick(19, 1);
    repeat (3) @(posedge clk);

    // Zero steps without hold: done next cycle, stays IDLE
    push_ev(0, 1, 0, 0, 0, 1, 4'b0001);
    send_cmd(1'b0, 8'd0, 1'b0);
    repeat (5) @(posedge clk);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1 end_req = 1'b1;
  end
endmodule

// File: doc/dmfb_move_sequencer.md
# dmfb_move_sequencer

Sequences droplet train moves on the DMFB electrode array. Accepts move commands over a valid/ready handshake and steps a one-hot electrode phase pattern forward or backward, one phase per period tick. It owns the period timer's mode and restart lines: fast 60 ms period while stepping, slow 2 s period while holding a droplet in place. Sits between the host/command logic and the voltage-generator output stage, and consumes the timer's clockOut as its tick.

## Interface
Parameters:
- PHASES, 4, number of electrode phases in the repeating drive pattern (≥2, need not be a power of two)
- CNT_W, 8, width of the step-count field

Ports:
- clockIn  in  1  system clock; all logic on rising edge
- reset_t  in  1  reset; synchronous and active-high
- tickIn  in  1  period timer clockOut (level); rising edges are detected internally
- cmd_valid  in  1  move command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_dir  in  1  0 = forward (phase index +1), 1 = reverse (−1)
- cmd_steps  in  CNT_W  number of phase steps to perform
- cmd_hold  in  1  after the last step, hold for one slow period
- abort  in  1  cancel the current move
- clockControl  out  1  timer mode: 0 = 60 ms period, 1 = 2 s period
- timer_reset  out  1  one-cycle timer restart, drives the timer's reset_t
- phase_out  out  PHASES  one-hot electrode enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a move completes normally

## Operation
- States: IDLE, ARM, STEP, HOLD. Registers: phase index (clog2(PHASES) bits), remaining count (CNT_W bits), latched dir, latched hold, tick_q.
- Tick edge: tick_rise = tickIn & ~tick_q. tick_q updates every cycle in every state.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch dir, steps and hold.
  - steps≠0: go to ARM.
  - steps=0, hold=1: go to HOLD. timer_reset pulses on entry; clockControl=1.
  - steps=0, hold=0: pulse done next cycle and stay in IDLE.
- ARM: one cycle. timer_reset=1, clockControl=0. Then go to STEP. tick_rise is ignored in ARM.
- STEP: clockControl=0. On tick_rise, phase index moves ±1 modulo PHASES (0−1 wraps to PHASES−1; PHASES−1+1 wraps to 0) and remaining decrements. When a tick_rise occurs with remaining=1:
  - hold=1: go to HOLD; timer_reset=1 for that cycle; clockControl=1.
  - hold=0: go to IDLE and pulse done.
- HOLD: clockControl=1. The first tick_rise goes to IDLE and pulses done. phase_out is unchanged.
- abort in ARM/STEP/HOLD: go to IDLE next cycle, keep phase index, no done pulse. abort in IDLE has no effect.
- Priority: reset_t > abort > tick_rise.
- phase_out = one-hot(phase index) at all times. The droplet stays on its last electrode while IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready=0). Commands are never queued.
- clockControl is 0 in IDLE.

## Timing
- Reset values: state IDLE, phase index 0 (phase_out = 1 in the LSB), remaining 0, tick_q 0, cmd_ready 1, busy 0, done 0, timer_reset 0, clockControl 0.
- Reset mid-move discards the command and applies the reset values on the next edge.
- Command accepted at edge N: ARM during cycle N+1 with timer_reset high; STEP from N+2.
- phase_out changes at the edge where tick_rise is sampled high, so it is registered with zero additional latency.
- done is asserted in the cycle after the completing edge, for exactly one cycle. cmd_ready returns high in that same cycle.
- timer_reset is high for exactly one full clockIn cycle, so the timer's falling-edge logic samples it.
- A tickIn that stays high produces only one step.

## Structure
- Shared package dmfb_pkg holds the state enum (IDLE/ARM/STEP/HOLD), PHASES default, and the clockControl encodings (FAST=0, SLOW=1) that the timer also uses.
- One sub-module: dmfb_tick_edge, which registers tickIn and outputs tick_rise.
- Everything else is a single FSM plus counters.

## Test plan
- Reset, then cmd dir=0, steps=5, hold=0, one tick every 20 cycles → phase_out goes 0001→0010→0100→1000→0001→0010; done pulses once; cmd_ready back to 1; clockControl 0 throughout.
- dir=1, steps=2 from phase 0 → phase_out goes 1000 then 0100 (wrap-around).
- steps=3, hold=1 → timer_reset pulses in ARM and after the third step; clockControl=1 in HOLD; done pulses one cycle after the next tick.
- abort asserted after 2 of 6 steps → IDLE next cycle, phase_out stays at the phase-2 pattern, no done pulse.
- tickIn held high for 50 cycles during STEP → exactly one step. cmd_valid asserted during STEP → ignored, cmd_ready=0.
- reset_t asserted in HOLD → phase_out=0001, clockControl=0, busy=0 on the next edge.
